udp_ack_parser: RTL and testbench
=================================

Name: udp_ack_parser

Overview:
- Receive-side counterpart of the ACK transmit path: parses 8-bit AXI-Stream Ethernet frames from the MAC RX path and detects UDP ACK packets addressed to this node.
- Checks the Ethernet, IPv4 and UDP headers and the 3-byte ACK opcode, then extracts the 12-bit acknowledged index.
- Reports each valid ACK as a single-cycle pulse to the system FSM; all other frames are discarded and counted.

Parameters:
MY_MAC, 48'h02_00_00_00_00_00, required destination MAC (exact match; broadcast is not accepted)
MY_IP, {8'd192,8'd168,8'd1,8'd50}, required IPv4 destination address
MY_PORT, 16'd50000, required UDP destination port
OP_ACK, 24'hAA0000, required payload opcode (payload bytes 0-2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  8  frame byte; first beat is the first destination-MAC byte
s_axis_tvalid  in  1  byte valid
s_axis_tready  out  1  0 while rst is high, otherwise 1 (the block never back-pressures)
s_axis_tlast  in  1  last byte of frame
s_axis_tuser  in  1  MAC error flag; sampled only on the tlast beat
o_ack_valid  out  1  one-cycle pulse when a valid ACK has been received
o_ack_index  out  12  index from the last valid ACK; held until the next one
o_rx_ok_count  out  16  count of accepted ACK frames; saturates at 16'hFFFF
o_rx_drop_count  out  16  count of discarded frames; saturates at 16'hFFFF

Behaviour:
- Beat = cycle with s_axis_tvalid && s_axis_tready. The byte counter advances only on beats. Gaps in tvalid are legal and change nothing.
- Reset values: s_axis_tready 0, o_ack_valid 0, o_ack_index 0, both counters 0, state S_IDLE, byte counter 0, index staging register 0.
- Byte counter is 7 bits and saturates at 127. Frames longer than 127 bytes are legal; trailing bytes are ignored until tlast.
- Field checks, by byte offset in the frame:
  - 0-5: equal MY_MAC, MSB first.
  - 12-13: 8'h08, 8'h00.
  - 14: 8'h45.
  - 23: 8'h11.
  - 30-33: equal MY_IP, MSB first.
  - 36-37: equal MY_PORT, MSB first.
  - 42-44: equal OP_ACK, MSB first.
  - 45: upper nibble must be 0; lower nibble goes to index[11:8].
  - 46: goes to index[7:0].
  - All other bytes (source MAC/IP, length, IP checksum, source port, UDP checksum, padding) are not checked.
- States:
  - S_IDLE: the first beat moves to S_RECV with the counter at 1, after checking byte 0. A first beat that also carries tlast is a runt and is dropped.
  - S_RECV: checks each byte at its offset. Any mismatch moves to S_DROP. Index bytes go to a staging register, not to o_ack_index.
  - S_DROP: discards beats until the tlast beat, then returns to S_IDLE and increments o_rx_drop_count.
  - tlast beat in S_RECV: the frame is accepted only if all of these hold:
    - the byte at offset 46 has been received (frame length >= 47);
    - the tlast byte itself passes any check at its offset;
    - s_axis_tuser = 0.
  - On accept: on the next clock edge, o_ack_valid = 1 for exactly one cycle, o_ack_index is loaded from staging, and o_rx_ok_count increments. Otherwise o_rx_drop_count increments. Either way, return to S_IDLE.
  - Latency from the tlast beat to the o_ack_valid high cycle is 1 cycle.
- A new frame may start on the beat immediately after tlast (zero idle cycles). A pending o_ack_valid pulse is unaffected by it.
- Reset mid-frame: return to reset values at once with no output pulse and no counter change. After rst deasserts, the remaining tail of the frame is parsed as a new frame, fails its checks and is counted as one drop.
- Counters saturate: at 16'hFFFF they hold their value, and o_ack_valid still pulses.

Test Plan:
- 60-byte ACK frame (dst MAC 02:00:00:00:00:00, 0x0800, 0x45, proto 0x11, dst IP 192.168.1.50, dst port 0xC350, payload AA 00 00 0A BC, zero padding) -> o_ack_valid high exactly 1 cycle after tlast, o_ack_index = 12'hABC, ok_count = 1, drop_count = 0.
- Same frame with random tvalid gaps, sent back-to-back with a second frame carrying index 0x001 -> two pulses with indexes 12'hABC then 12'h001, ok_count = 2.
- Separate frames each with one fault -> no pulse, drop_count +1 each, o_ack_index keeps its previous value:
  - dst MAC byte 5 = 0x01;
  - opcode byte 44 = 0x01;
  - byte 45 = 0x1A;
  - s_axis_tuser = 1 on tlast.
- Runt frame with tlast at byte 40, and a single-beat frame -> drop_count +2, no pulse.
- rst asserted for 1 cycle at byte 20 of a valid ACK frame -> s_axis_tready is 0 during rst; the tail is dropped (drop_count = 1); the next full valid frame is accepted.
- Force ok_count to 16'hFFFF (send 65535 frames or preload in sim), then send a valid frame -> pulse occurs, count stays 16'hFFFF.

Source files
------------

// File: rtl/udp_ack_parser.sv
// UDP ACK receive parser: validates Ethernet/IPv4/UDP headers and the ACK opcode on an
// 8-bit AXI-Stream, then reports the 12-bit acknowledged index as a one-cycle pulse.
module udp_ack_parser #(
  parameter logic [47:0] MY_MAC  = 48'h02_00_00_00_00_00,
  parameter logic [31:0] MY_IP   = {8'd192, 8'd168, 8'd1, 8'd50},
  parameter logic [15:0] MY_PORT = 16'd50000,
  parameter logic [23:0] OP_ACK  = 24'hAA0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        o_ack_valid,
  output logic [11:0] o_ack_index,
  output logic [15:0] o_rx_ok_count,
  output logic [15:0] o_rx_drop_count
);

  typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

  state_e      state_q;
  logic [6:0]  cnt_q;
  logic [11:0] stage_q;
  logic [11:0] idx_next;
  logic        byte_ok;
  logic        beat;

  assign s_axis_tready = ~rst;
  assign beat          = s_axis_tvalid & s_axis_tready;

  // cnt_q is the offset of the byte currently on the bus (0 while idle).
  always_comb begin
    byte_ok = 1'b1;
    case (cnt_q)
      7'd0:  byte_ok = (s_axis_tdata == MY_MAC[47:40]);
      7'd1:  byte_ok = (s_axis_tdata == MY_MAC[39:32]);
      7'd2:  byte_ok = (s_axis_tdata == MY_MAC[31:24]);
      7'd3:  byte_ok = (s_axis_tdata == MY_MAC[23:16]);
      7'd4:  byte_ok = (s_axis_tdata == MY_MAC[15:8]);
      7'd5:  byte_ok = (s_axis_tdata == MY_MAC[7:0]);
      7'd12: byte_ok = (s_axis_tdata == 8'h08);
      7'd13: byte_ok = (s_axis_tdata == 8'h00);
      7'd14: byte_ok = (s_axis_tdata == 8'h45);
      7'd23: byte_ok = (s_axis_tdata == 8'h11);
      7'd30: byte_ok = (s_axis_tdata == MY_IP[31:24]);
      7'd31: byte_ok = (s_axis_tdata == MY_IP[23:16]);
      7'd32: byte_ok = (s_axis_tdata == MY_IP[15:8]);
      7'd33: byte_ok = (s_axis_tdata == MY_IP[7:0]);
      7'd36: byte_ok = (s_axis_tdata == MY_PORT[15:8]);
      7'd37: byte_ok = (s_axis_tdata == MY_PORT[7:0]);
      7'd42: byte_ok = (s_axis_tdata == OP_ACK[23:16]);
      7'd43: byte_ok = (s_axis_tdata == OP_ACK[15:8]);
      7'd44: byte_ok = (s_axis_tdata == OP_ACK[7:0]);
      7'd45: byte_ok = (s_axis_tdata[7:4] == 4'h0);
      default: byte_ok = 1'b1;
    endcase
  end

  // Staging including the current byte, so a tlast on offset 46 sees the full index.
  always_comb begin
    idx_next = stage_q;
    if (cnt_q == 7'd45) idx_next[11:8] = s_axis_tdata[3:0];
    if (cnt_q == 7'd46) idx_next[7:0]  = s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= 7'd0;
      stage_q         <= 12'd0;
      o_ack_valid     <= 1'b0;
      o_ack_index     <= 12'd0;
      o_rx_ok_count   <= 16'd0;
      o_rx_drop_count <= 16'd0;
    end else begin
      o_ack_valid <= 1'b0;
      if (beat) begin
        case (state_q)
          StIdle: begin
            if (s_axis_tlast) begin
              if (o_rx_drop_count != 16'hFFFF) o_rx_drop_count <= o_rx_drop_count + 16'd1;
            end else begin
              cnt_q   <= 7'd1;
              state_q <= byte_ok ? StRecv : StDrop;
            end
          end
          StRecv: begin
            stage_q <= idx_next;
            if (s_axis_tlast) begin
              cnt_q   <= 7'd0;
              state_q <= StIdle;
              if (cnt_q >= 7'd46 && byte_ok && !s_axis_tuser) begin
                o_ack_valid <= 1'b1;
                o_ack_index <= idx_next;
                if (o_rx_ok_count != 16'hFFFF) o_rx_ok_count <= o_rx_ok_count + 16'd1;
              end else if (o_rx_drop_count != 16'hFFFF) begin
                o_rx_drop_count <= o_rx_drop_count + 16'd1;
              end
            end else begin
              if (!byte_ok) state_q <= StDrop;
              if (cnt_q != 7'd127) cnt_q <= cnt_q + 7'd1;
            end
          end
          StDrop: begin
            if (s_axis_tlast) begin
              cnt_q   <= 7'd0;
              state_q <= StIdle;
              if (o_rx_drop_count != 16'hFFFF) o_rx_drop_count <= o_rx_drop_count + 16'd1;
            end
          end
          default: begin
            cnt_q   <= 7'd0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_ack_parser.sv
// Directed bench for udp_ack_parser: builds ACK frames byte by byte and checks pulses/counters.
module tb_udp_ack_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        o_ack_valid;
  logic [11:0] o_ack_index;
  logic [15:0] o_rx_ok_count;
  logic [15:0] o_rx_drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  logic [11:0] pulse_idx[$];
  logic [7:0]  frm [0:63];

  udp_ack_parser dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .o_ack_valid     (o_ack_valid),
    .o_ack_index     (o_ack_index),
    .o_rx_ok_count   (o_rx_ok_count),
    .o_rx_drop_count (o_rx_drop_count)
  );

  always #5 clk = ~clk;

  // Every high cycle is logged, so a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (o_ack_valid === 1'b1) begin
      pulse_cnt++;
      pulse_idx.push_back(o_ack_index);
    end
  end

  task automatic build_frame(input logic [11:0] idx);
    for (int i = 0; i < 64; i++) frm[i] = 8'h00;
    frm[0] = 8'h02;
    frm[6] = 8'h02; frm[11] = 8'h01;
    frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45;
    frm[17] = 8'h21; frm[22] = 8'h40; frm[23] = 8'h11;
    frm[26] = 8'hC0; frm[27] = 8'hA8; frm[28] = 8'h01; frm[29] = 8'h0A;
    frm[30] = 8'hC0; frm[31] = 8'hA8; frm[32] = 8'h01; frm[33] = 8'h32;
    frm[34] = 8'h12; frm[35] = 8'h34; frm[36] = 8'hC3; frm[37] = 8'h50;
    frm[39] = 8'h0D;
    frm[42] = 8'hAA; frm[43] = 8'h00; frm[44] = 8'h00;
    frm[45] = {4'h0, idx[11:8]};
    frm[46] = idx[7:0];
  endtask

  // Sends frm[first .. last_off], tlast on last_off; returns at tlast edge + 1.
  task automatic send_frame(input int first, input int last_off, input bit gaps, input bit user);
    for (int i = first; i <= last_off; i++) begin
      if (gaps && i > first) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          s_axis_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_axis_tdata  = frm[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == last_off);
      s_axis_tuser  = (i == last_off) ? user : 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = 8'h00;
    idle(3);
    n_checks++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready);
    end
    n_checks++;
    if (o_ack_valid !== 1'b0 || o_ack_index !== 12'h000) begin
      n_fail++; $display("FAIL reset_ack: got valid=%b idx=%h expected 0/000", o_ack_valid, o_ack_index);
    end
    n_checks++;
    if (o_rx_ok_count !== 16'd0 || o_rx_drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: got ok=%0d drop=%0d expected 0/0", o_rx_ok_count, o_rx_drop_count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b expected 1", s_axis_tready);
    end
    idle(1);
  endtask

  task automatic test_basic;
    build_frame(12'hABC);
    send_frame(0, 59, 1'b0, 1'b0);
    n_checks++;
    if (o_ack_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency: got valid=%b expected 1 one cycle after tlast", o_ack_valid);
    end
    n_checks++;
    if (o_ack_index !== 12'hABC) begin
      n_fail++; $display("FAIL basic_index: got %h expected abc", o_ack_index);
    end
    idle(1);
    n_checks++;
    if (o_ack_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse_width: got valid=%b expected 0", o_ack_valid);
    end
    n_checks++;
    if (o_rx_ok_count !== 16'd1 || o_rx_drop_count !== 16'd0) begin
      n_fail++; $display("FAIL basic_counts: got ok=%0d drop=%0d expected 1/0", o_rx_ok_count, o_rx_drop_count);
    end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulse_cnt;
    pulse_idx.delete();
    build_frame(12'hABC);
    send_frame(0, 59, 1'b1, 1'b0);
    build_frame(12'h001);
    send_frame(0, 59, 1'b0, 1'b0);
    idle(3);
    n_checks++;
    if (pulse_cnt - p0 !== 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d pulse cycles expected 2", pulse_cnt - p0);
    end else begin
      n_checks++;
      if (pulse_idx[0] !== 12'hABC || pulse_idx[1] !== 12'h001) begin
        n_fail++; $display("FAIL b2b_indexes: got %h,%h expected abc,001", pulse_idx[0], pulse_idx[1]);
      end
    end
    n_checks++;
    if (o_rx_ok_count !== 16'd3 || o_rx_drop_count !== 16'd0) begin
      n_fail++; $display("FAIL b2b_counts: got ok=%0d drop=%0d expected 3/0", o_rx_ok_count, o_rx_drop_count);
    end
  endtask

  task automatic test_faults;
    int p0;
    logic [15:0] d0;
    for (int f = 0; f < 4; f++) begin
      p0 = pulse_cnt;
      d0 = o_rx_drop_count;
      build_frame(12'h5C3);
      case (f)
        0: frm[5]  = 8'h01;
        1: frm[44] = 8'h01;
        2: frm[45] = 8'h1A;
        default: ;
      endcase
      send_frame(0, 59, 1'b0, f == 3);
      idle(2);
      n_checks++;
      if (pulse_cnt !== p0 || o_ack_index !== 12'h001) begin
        n_fail++;
        $display("FAIL fault%0d_no_ack: got pulses=%0d idx=%h expected 0/001", f, pulse_cnt - p0, o_ack_index);
      end
      n_checks++;
      if (o_rx_drop_count !== d0 + 16'd1 || o_rx_ok_count !== 16'd3) begin
        n_fail++;
        $display("FAIL fault%0d_counts: got ok=%0d drop=%0d expected 3/%0d", f, o_rx_ok_count, o_rx_drop_count, d0 + 16'd1);
      end
    end
  endtask

  task automatic test_runt;
    int p0;
    logic [15:0] d0;
    p0 = pulse_cnt;
    d0 = o_rx_drop_count;
    build_frame(12'h777);
    send_frame(0, 40, 1'b0, 1'b0);
    send_frame(0, 0, 1'b0, 1'b0);
    idle(2);
    n_checks++;
    if (pulse_cnt !== p0 || o_rx_drop_count !== d0 + 16'd2) begin
      n_fail++;
      $display("FAIL runt: got pulses=%0d drop=%0d expected 0/%0d", pulse_cnt - p0, o_rx_drop_count, d0 + 16'd2);
    end
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    build_frame(12'h246);
    for (int i = 0; i < 20; i++) begin
      s_axis_tdata = frm[i]; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tdata = frm[20];
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_tready: got %b expected 0", s_axis_tready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pulse_cnt;
    n_checks++;
    if (o_rx_ok_count !== 16'd0 || o_rx_drop_count !== 16'd0 || o_ack_index !== 12'h000) begin
      n_fail++;
      $display("FAIL midrst_state: got ok=%0d drop=%0d idx=%h expected 0/0/000", o_rx_ok_count, o_rx_drop_count, o_ack_index);
    end
    send_frame(20, 59, 1'b0, 1'b0);
    idle(2);
    n_checks++;
    if (o_rx_drop_count !== 16'd1 || o_rx_ok_count !== 16'd0 || pulse_cnt !== p0) begin
      n_fail++;
      $display("FAIL midrst_tail: got ok=%0d drop=%0d pulses=%0d expected 0/1/0", o_rx_ok_count, o_rx_drop_count, pulse_cnt - p0);
    end
    send_frame(0, 59, 1'b0, 1'b0);
    idle(2);
    n_checks++;
    if (o_rx_ok_count !== 16'd1 || o_ack_index !== 12'h246 || pulse_cnt !== p0 + 1) begin
      n_fail++;
      $display("FAIL midrst_next: got ok=%0d idx=%h pulses=%0d expected 1/246/1", o_rx_ok_count, o_ack_index, pulse_cnt - p0);
    end
  endtask

  task automatic test_saturation;
    int p0;
    force dut.o_rx_ok_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.o_rx_ok_count;
    p0 = pulse_cnt;
    build_frame(12'h5A5);
    send_frame(0, 46, 1'b0, 1'b0);
    idle(2);
    n_checks++;
    if (pulse_cnt !== p0 + 1 || o_ack_index !== 12'h5A5) begin
      n_fail++; $display("FAIL sat_pulse: got pulses=%0d idx=%h expected 1/5a5", pulse_cnt - p0, o_ack_index);
    end
    n_checks++;
    if (o_rx_ok_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_count: got %h expected ffff", o_rx_ok_count);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_faults;
    test_runt;
    test_reset_mid_frame;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
